// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions and the
// decode-stage run/halt state encoding.
package cpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_XOR  = 4'h4;
  localparam logic [3:0] OP_SLL  = 4'h5;
  localparam logic [3:0] OP_SRL  = 4'h6;
  localparam logic [3:0] OP_ADDI = 4'h7;
  localparam logic [3:0] OP_LLI  = 4'h8;
  localparam logic [3:0] OP_LHI  = 4'h9;
  localparam logic [3:0] OP_LD   = 4'hA;
  localparam logic [3:0] OP_ST   = 4'hB;
  localparam logic [3:0] OP_B    = 4'hC;
  localparam logic [3:0] OP_JAL  = 4'hD;
  localparam logic [3:0] OP_JR   = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_LSB = 12;
  localparam int RD_LSB = 8;
  localparam int RS_LSB = 4;
  localparam int RT_LSB = 0;

  localparam logic [3:0] LINK_REG = 4'd15;

  typedef enum logic {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  typedef struct packed {
    logic reads_a;
    logic reads_b;
    logic b_is_rd;
    logic reg_we;
    logic mem_re;
    logic mem_we;
    logic branch;
  } ctrl_t;

endpackage

// File: rtl/reg_file.sv
// 2-read / 1-write register file with write-through bypass; r0 reads as zero.
module reg_file #(
  parameter int NREGS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  raddr_a,
  input  logic [3:0]  raddr_b,
  output logic [15:0] rdata_a,
  output logic [15:0] rdata_b,
  input  logic        wb_we,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data
);

  logic [15:0] regs [NREGS];

  // NOTE: the array is cleared on reset because software relies on every
  // register starting at zero; this costs a reset net per flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++) begin
        if (wb_we && wb_addr == i[3:0]) regs[i] <= wb_data;
      end
    end
  end

  function automatic logic [15:0] read_port(input logic [3:0] addr);
    if (addr == 4'd0)                  return 16'h0000;
    else if (wb_we && addr == wb_addr) return wb_data;
    else                               return regs[addr];
  endfunction

  assign rdata_a = read_port(raddr_a);
  assign rdata_b = read_port(raddr_b);

endmodule

// File: rtl/decode_stage.sv
// Decode stage: instruction decode, operand read, load-use hazard detection,
// ID/EX pipeline register and sticky HALT state.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] pc,
  input  logic [15:0] inst,
  input  logic        inst_invalid,
  input  logic        flush,
  input  logic        wb_we,
  input  logic [3:0]  wb_addr,
  input  logic [15:0] wb_data,
  output logic        stall,
  output logic        id_valid,
  output logic [15:0] id_pc,
  output logic [3:0]  id_op,
  output logic [3:0]  id_rd,
  output logic [15:0] id_a,
  output logic [15:0] id_b,
  output logic [15:0] id_imm,
  output logic        id_reg_we,
  output logic        id_mem_re,
  output logic        id_mem_we,
  output logic        id_branch,
  output logic        halted
);

  state_t state, state_next;

  logic [3:0]  op, rd, rs, rt, b_addr, dest;
  logic [15:0] imm, rdata_a, rdata_b;
  ctrl_t       ctrl;
  logic        hazard, bubble;

  assign op = inst[OP_LSB +: 4];
  assign rd = inst[RD_LSB +: 4];
  assign rs = inst[RS_LSB +: 4];
  assign rt = inst[RT_LSB +: 4];

  // NOTE: every signal is given a default before the case so no path leaves
  // one unassigned, which would otherwise infer a latch.
  always_comb begin
    ctrl = '0;
    imm  = '0;
    dest = rd;
    unique case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SRL: begin
        ctrl.reads_a = 1'b1;
        ctrl.reads_b = 1'b1;
        ctrl.reg_we  = 1'b1;
      end
      OP_ADDI, OP_LD: begin
        ctrl.reads_a = 1'b1;
        ctrl.reg_we  = 1'b1;
        ctrl.mem_re  = (op == OP_LD);
        imm          = {{12{inst[3]}}, inst[3:0]};
      end
      OP_ST: begin
        ctrl.reads_a = 1'b1;
        ctrl.reads_b = 1'b1;
        ctrl.b_is_rd = 1'b1;
        ctrl.mem_we  = 1'b1;
        imm          = {{12{inst[3]}}, inst[3:0]};
      end
      OP_LLI, OP_LHI: begin
        ctrl.reads_b = 1'b1;
        ctrl.b_is_rd = 1'b1;
        ctrl.reg_we  = 1'b1;
        imm          = {8'h00, inst[7:0]};
      end
      OP_B: begin
        ctrl.branch = 1'b1;
        imm         = {{8{inst[7]}}, inst[7:0]};
      end
      OP_JAL: begin
        ctrl.branch = 1'b1;
        ctrl.reg_we = 1'b1;
        dest        = LINK_REG;
        imm         = {{8{inst[7]}}, inst[7:0]};
      end
      OP_JR: begin
        ctrl.reads_a = 1'b1;
        ctrl.branch  = 1'b1;
      end
      default: ;  // HALT: no operands, no side effects
    endcase
  end

  assign b_addr = ctrl.b_is_rd ? rd : rt;

  reg_file #(.NREGS(NREGS)) u_reg_file (
    .clk     (clk),
    .rst_n   (rst_n),
    .raddr_a (rs),
    .raddr_b (b_addr),
    .rdata_a (rdata_a),
    .rdata_b (rdata_b),
    .wb_we   (wb_we),
    .wb_addr (wb_addr),
    .wb_data (wb_data)
  );

  assign hazard = id_valid && id_mem_re && (id_rd != 4'd0) &&
                  ((ctrl.reads_a && rs == id_rd) ||
                   (ctrl.reads_b && b_addr == id_rd));

  assign bubble = flush || (state == ST_HALT) || inst_invalid || hazard;

  // Flush wins so fetch can redirect; an invalid slot never needs a replay.
  assign stall  = !flush && ((state == ST_HALT) || (hazard && !inst_invalid));
  assign halted = (state == ST_HALT);

  always_comb begin
    state_next = state;
    if (state == ST_RUN && !bubble && op == OP_HALT) state_next = ST_HALT;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      id_valid  <= 1'b0;
      id_pc     <= '0;
      id_op     <= '0;
      id_rd     <= '0;
      id_a      <= '0;
      id_b      <= '0;
      id_imm    <= '0;
      id_reg_we <= 1'b0;
      id_mem_re <= 1'b0;
      id_mem_we <= 1'b0;
      id_branch <= 1'b0;
    end else begin
      state     <= state_next;
      id_valid  <= !bubble;
      id_pc     <= pc;
      id_op     <= op;
      id_rd     <= dest;
      id_a      <= rdata_a;
      id_b      <= rdata_b;
      id_imm    <= imm;
      id_reg_we <= ctrl.reg_we && !bubble;
      id_mem_re <= ctrl.mem_re && !bubble;
      id_mem_we <= ctrl.mem_we && !bubble;
      id_branch <= ctrl.branch && !bubble;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: bypass, load-use stall,
// flush priority, immediates, bubbles, r0 and sticky HALT.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] pc, inst;
  logic        inst_invalid, flush, wb_we;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        stall, id_valid, id_reg_we, id_mem_re, id_mem_we, id_branch, halted;
  logic [15:0] id_pc, id_a, id_b, id_imm;
  logic [3:0]  id_op, id_rd;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pc           (pc),
    .inst         (inst),
    .inst_invalid (inst_invalid),
    .flush        (flush),
    .wb_we        (wb_we),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data),
    .stall        (stall),
    .id_valid     (id_valid),
    .id_pc        (id_pc),
    .id_op        (id_op),
    .id_rd        (id_rd),
    .id_a         (id_a),
    .id_b         (id_b),
    .id_imm       (id_imm),
    .id_reg_we    (id_reg_we),
    .id_mem_re    (id_mem_re),
    .id_mem_we    (id_mem_we),
    .id_branch    (id_branch),
    .halted       (halted)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%04h, expected 0x%04h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and let the combinational stall settle.
  task automatic present(input logic [15:0] p, input logic [15:0] i);
    pc   = p;
    inst = i;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; pc = '0; inst = 16'h0000; inst_invalid = 1'b0; flush = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    #3;
    check("rst_valid",  {15'd0, id_valid}, 16'd0);
    check("rst_halted", {15'd0, halted},   16'd0);
    check("rst_stall",  {15'd0, stall},    16'd0);
    check("rst_pc",     id_pc,             16'h0000);
    check("rst_a",      id_a,              16'h0000);
    step();
    rst_n = 1'b1;
    inst_invalid = 1'b1;
    wb_we = 1'b1; wb_addr = 4'd0; wb_data = 16'hFFFF;   // write to r0 is dropped
    step();
    wb_we = 1'b0; inst_invalid = 1'b0;

    // ADDI r1,r0,5
    present(16'h0010, 16'h7105);
    check("addi_stall", {15'd0, stall}, 16'd0);
    step();
    check("addi_valid", {15'd0, id_valid}, 16'd1);
    check("addi_op",    {12'd0, id_op},    16'h0007);
    check("addi_rd",    {12'd0, id_rd},    16'h0001);
    check("addi_imm",   id_imm,            16'h0005);
    check("addi_we",    {15'd0, id_reg_we}, 16'd1);
    check("addi_pc",    id_pc,             16'h0010);

    // ADD r2,r1,r1 with writeback of r1=5 in the same cycle
    wb_we = 1'b1; wb_addr = 4'd1; wb_data = 16'h0005;
    present(16'h0011, 16'h0211);
    check("add_stall", {15'd0, stall}, 16'd0);
    step();
    wb_we = 1'b0;
    check("byp_a",     id_a, 16'h0005);
    check("byp_b",     id_b, 16'h0005);
    check("add_valid", {15'd0, id_valid}, 16'd1);

    // LD r3,[r1+2] then ADD r4,r3,r0: one stall, one bubble
    present(16'h0012, 16'hA312);
    check("ld_stall", {15'd0, stall}, 16'd0);
    step();
    check("ld_re",  {15'd0, id_mem_re}, 16'd1);
    check("ld_imm", id_imm, 16'h0002);
    check("ld_a",   id_a,   16'h0005);
    present(16'h0013, 16'h0430);
    check("lu_stall", {15'd0, stall}, 16'd1);
    step();
    check("lu_bubble", {15'd0, id_valid}, 16'd0);
    check("lu_bub_we", {15'd0, id_reg_we}, 16'd0);
    #1;
    check("lu_stall_clr", {15'd0, stall}, 16'd0);
    step();
    check("lu_issue", {15'd0, id_valid}, 16'd1);
    check("lu_rd",    {12'd0, id_rd},    16'h0004);
    check("lu_pc",    id_pc,             16'h0013);

    // Flush coincident with a load-use hazard
    present(16'h0014, 16'hA312);
    step();
    flush = 1'b1;
    present(16'h0015, 16'h0430);
    check("fl_stall", {15'd0, stall}, 16'd0);
    step();
    flush = 1'b0;
    check("fl_valid", {15'd0, id_valid}, 16'd0);

    // ST r5,[r1-2]
    present(16'h0016, 16'hB51E);
    step();
    check("st_imm",   id_imm, 16'hFFFE);
    check("st_mwe",   {15'd0, id_mem_we}, 16'd1);
    check("st_rwe",   {15'd0, id_reg_we}, 16'd0);
    check("st_a",     id_a, 16'h0005);

    // LLI r6,0x80
    present(16'h0017, 16'h8680);
    step();
    check("lli_imm", id_imm, 16'h0080);
    check("lli_we",  {15'd0, id_reg_we}, 16'd1);

    // JAL -2: link into r15
    present(16'h0018, 16'hD0FE);
    step();
    check("jal_rd",  {12'd0, id_rd}, 16'h000F);
    check("jal_imm", id_imm, 16'hFFFE);
    check("jal_br",  {15'd0, id_branch}, 16'd1);

    // Invalid slot carrying a store opcode
    inst_invalid = 1'b1;
    present(16'h0019, 16'hB51E);
    step();
    inst_invalid = 1'b0;
    check("inv_mwe",   {15'd0, id_mem_we}, 16'd0);
    check("inv_valid", {15'd0, id_valid},  16'd0);

    // r0 reads zero, even with a concurrent write to r0
    wb_we = 1'b1; wb_addr = 4'd0; wb_data = 16'hFFFF;
    present(16'h001A, 16'h7700);
    step();
    wb_we = 1'b0;
    check("r0_read", id_a, 16'h0000);

    // HALT is sticky until reset
    present(16'h001B, 16'hF000);
    check("halt_pre", {15'd0, halted}, 16'd0);
    step();
    check("halt_set",   {15'd0, halted},   16'd1);
    check("halt_valid", {15'd0, id_valid}, 16'd1);
    present(16'h001C, 16'h0211);
    check("halt_stall", {15'd0, stall}, 16'd1);
    step();
    check("halt_bub",  {15'd0, id_valid}, 16'd0);
    check("halt_stay", {15'd0, halted},   16'd1);
    rst_n = 1'b0;
    #1;
    check("halt_rst",   {15'd0, halted}, 16'd0);
    check("halt_rst_s", {15'd0, stall},  16'd0);
    step();
    rst_n = 1'b1;
    step();
    check("post_rst_valid", {15'd0, id_valid}, 16'd1);
    check("post_rst_halt",  {15'd0, halted},   16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
